// File: rtl/power_accum.sv
// Instantaneous power I^2+Q^2 integrated over a fixed window of 2^ACC_LEN_LOG2 valid samples.
// Three-stage pipeline: square, add, accumulate; window sum is held on dout between windows.
module power_accum #(
  parameter int IQ_WIDTH     = 16,
  parameter int ACC_LEN_LOG2 = 10,
  parameter int DOUT_WIDTH   = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [IQ_WIDTH-1:0] din_i,
  input  logic signed [IQ_WIDTH-1:0] din_q,
  input  logic                       din_valid,
  input  logic                       clr,
  output logic [DOUT_WIDTH-1:0]      dout,
  output logic                       dout_valid
);

  localparam int SQ_W  = 2 * IQ_WIDTH;
  localparam int ACC_W = SQ_W + ACC_LEN_LOG2;

  if (ACC_LEN_LOG2 < 1 || ACC_LEN_LOG2 > 20 || ACC_W > DOUT_WIDTH) begin : g_param_check
    $error("power_accum: ACC_LEN_LOG2 must be 1..20 and 2*IQ_WIDTH+ACC_LEN_LOG2 <= DOUT_WIDTH");
  end

  logic signed [SQ_W-1:0]     ext_i_s, ext_q_s;
  logic signed [SQ_W-1:0]     prod_i_s, prod_q_s;
  logic                       cnt_max_s;
  logic [ACC_W-1:0]           sum_s;

  logic [ACC_LEN_LOG2-1:0]    cnt_r;
  logic [SQ_W-1:0]            sq_i_r, sq_q_r;
  logic                       v1_r, last1_r;
  logic [SQ_W-1:0]            p_r;
  logic                       v2_r, last2_r;
  logic [ACC_W-1:0]           acc_r;
  logic [DOUT_WIDTH-1:0]      dout_r;
  logic                       dout_valid_r;

  // Squares are formed at full product width so the most negative input squares exactly.
  always_comb begin
    ext_i_s   = SQ_W'(din_i);
    ext_q_s   = SQ_W'(din_q);
    prod_i_s  = ext_i_s * ext_i_s;
    prod_q_s  = ext_q_s * ext_q_s;
    cnt_max_s = (cnt_r == {ACC_LEN_LOG2{1'b1}});
    sum_s     = acc_r + ACC_W'(p_r);
  end

  // Stage 1: square registers, sample counter and window-end tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_i_r  <= {SQ_W{1'b0}};
      sq_q_r  <= {SQ_W{1'b0}};
      v1_r    <= 1'b0;
      last1_r <= 1'b0;
      cnt_r   <= {ACC_LEN_LOG2{1'b0}};
    end else if (clr) begin
      v1_r    <= 1'b0;
      last1_r <= 1'b0;
      cnt_r   <= {ACC_LEN_LOG2{1'b0}};
    end else begin
      v1_r    <= din_valid;
      last1_r <= din_valid & cnt_max_s;
      if (din_valid) begin
        sq_i_r <= $unsigned(prod_i_s);
        sq_q_r <= $unsigned(prod_q_s);
        cnt_r  <= cnt_r + ACC_LEN_LOG2'(1'b1);
      end
    end
  end

  // Stage 2: instantaneous power; the sum of two squares fits in SQ_W bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r     <= {SQ_W{1'b0}};
      v2_r    <= 1'b0;
      last2_r <= 1'b0;
    end else if (clr) begin
      v2_r    <= 1'b0;
      last2_r <= 1'b0;
    end else begin
      p_r     <= sq_i_r + sq_q_r;
      v2_r    <= v1_r;
      last2_r <= last1_r;
    end
  end

  // Stage 3: window accumulation; a restart drops any window end still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r        <= {ACC_W{1'b0}};
      dout_r       <= {DOUT_WIDTH{1'b0}};
      dout_valid_r <= 1'b0;
    end else if (clr) begin
      acc_r        <= {ACC_W{1'b0}};
      dout_valid_r <= 1'b0;
    end else if (v2_r) begin
      if (last2_r) begin
        dout_r       <= DOUT_WIDTH'(sum_s);
        acc_r        <= {ACC_W{1'b0}};
        dout_valid_r <= 1'b1;
      end else begin
        acc_r        <= sum_s;
        dout_valid_r <= 1'b0;
      end
    end else begin
      dout_valid_r <= 1'b0;
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;

endmodule
